// File: rtl/alu_cmd_seq.sv
// Lab3 calculator front end: conditions the enter/sign buttons, captures two
// operands from the switches and issues ALU operations over valid/ready.

module alu_cmd_seq_btn #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (s2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= btn_i;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign pulse_o = deb_q & ~deb_prev_q;
endmodule

module alu_cmd_seq #(
  parameter int unsigned W               = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enter_btn,
  input  logic         sign_btn,
  input  logic [W-1:0] sw_in,
  input  logic         op_ready,
  output logic         op_valid,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic [3:0]   func,
  output logic         sign_mode,
  output logic [1:0]   phase
);
  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    ISSUE     = 2'd2,
    WAIT_NEXT = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]   idx_q, idx_d, idx_step;
  logic         sign_q, sign_d;
  logic         enter_p, sign_p;

  alu_cmd_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst(rst), .btn_i(enter_btn), .pulse_o(enter_p)
  );

  alu_cmd_seq_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sign (
    .clk(clk), .rst(rst), .btn_i(sign_btn), .pulse_o(sign_p)
  );

  // Index 3 is never produced, but recovers to 0 if it ever appears.
  assign idx_step = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    sign_d  = sign_q;
    case (state_q)
      LOAD_A: begin
        if (enter_p) begin
          a_d     = sw_in;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (enter_p) begin
          b_d     = sw_in;
          idx_d   = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_ready) state_d = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        if (enter_p) idx_d = idx_step;
        if (enter_p || sign_p) state_d = ISSUE;
      end
      default: state_d = LOAD_A;
    endcase
    if (sign_p && state_q != ISSUE) sign_d = ~sign_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= 2'd0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
    end
  end

  assign op_valid  = (state_q == ISSUE);
  assign operand_a = a_q;
  assign operand_b = b_q;
  assign func      = {sign_q, 1'b0, idx_q};
  assign sign_mode = sign_q;
  assign phase     = state_q;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Scoreboard bench for alu_cmd_seq: stimulus pushes expected issues, a monitor
// pops and compares them at each accepted handshake.

module tb_alu_cmd_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enter_btn = 1'b0;
  logic       sign_btn = 1'b0;
  logic [7:0] sw_in = '0;
  logic       op_ready = 1'b0;
  logic       op_valid;
  logic [7:0] operand_a, operand_b;
  logic [3:0] func;
  logic       sign_mode;
  logic [1:0] phase;

  int total = 0;
  int bad = 0;
  logic [19:0] exp_q[$];

  alu_cmd_seq #(.W(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enter_btn(enter_btn), .sign_btn(sign_btn),
    .sw_in(sw_in), .op_ready(op_ready), .op_valid(op_valid),
    .operand_a(operand_a), .operand_b(operand_b), .func(func),
    .sign_mode(sign_mode), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit e, input bit s, input int hold, input int gap);
    enter_btn = e;
    sign_btn  = s;
    repeat (hold) tick();
    enter_btn = 1'b0;
    sign_btn  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!op_valid && n < max) begin
      tick();
      n++;
    end
    chk("valid_arrive", {31'd0, op_valid}, 32'd1);
  endtask

  // Monitor: payload compare at each accepted handshake plus stability while stalled.
  logic        prev_valid = 1'b0;
  logic [19:0] prev_pay = '0;
  always @(negedge clk) begin
    logic [19:0] pay, e;
    pay = {operand_a, operand_b, func};
    if (rst) begin
      prev_valid = 1'b0;
    end else if (op_valid) begin
      chk("phase_in_issue", {30'd0, phase}, 32'd2);
      if (prev_valid) chk("payload_stable", {12'd0, pay}, {12'd0, prev_pay});
      if (op_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %0h expected none at %0t", pay, $time);
        end else begin
          e = exp_q.pop_front();
          chk("issue_payload", {12'd0, pay}, {12'd0, e});
        end
      end
      prev_valid = !op_ready;
      prev_pay   = pay;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_a", {24'd0, operand_a}, 32'd0);
    chk("rst_b", {24'd0, operand_b}, 32'd0);
    chk("rst_func", {28'd0, func}, 32'd0);
    chk("rst_sign", {31'd0, sign_mode}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op_ready = ~op_ready;
      tick();
    end
    chk("idle_phase", {30'd0, phase}, 32'd0);
    chk("idle_valid", {31'd0, op_valid}, 32'd0);

    // Capture and first issue
    op_ready = 1'b1;
    sw_in = 8'h2A;
    press(1, 0, 10, 10);
    chk("loadb_phase", {30'd0, phase}, 32'd1);
    chk("operand_a", {24'd0, operand_a}, 32'h2A);
    sw_in = 8'h05;
    exp_q.push_back({8'h2A, 8'h05, 4'b0000});
    press(1, 0, 10, 10);
    chk("wait_phase", {30'd0, phase}, 32'd3);
    chk("operand_b", {24'd0, operand_b}, 32'h05);
    sw_in = 8'hFF;

    // Operation stepping with wrap, then sign re-issue
    exp_q.push_back({8'h2A, 8'h05, 4'b0001});
    press(1, 0, 10, 10);
    exp_q.push_back({8'h2A, 8'h05, 4'b0010});
    press(1, 0, 10, 10);
    exp_q.push_back({8'h2A, 8'h05, 4'b0000});
    press(1, 0, 10, 10);
    exp_q.push_back({8'h2A, 8'h05, 4'b1000});
    press(0, 1, 10, 10);
    chk("sign_mode_set", {31'd0, sign_mode}, 32'd1);
    chk("operands_held", {16'd0, operand_a, operand_b}, 32'h2A05);

    // Short glitch is rejected
    enter_btn = 1'b1;
    repeat (2) tick();
    enter_btn = 1'b0;
    repeat (12) tick();
    chk("glitch_phase", {30'd0, phase}, 32'd3);
    chk("glitch_valid", {31'd0, op_valid}, 32'd0);

    // Clean press latency: state change on the 7th edge after the raw rise
    exp_q.push_back({8'h2A, 8'h05, 4'b1001});
    enter_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("deb_early", {31'd0, op_valid}, 32'd0);
    end
    tick();
    chk("deb_edge", {31'd0, op_valid}, 32'd1);
    repeat (3) tick();
    enter_btn = 1'b0;
    repeat (10) tick();

    // Backpressure: stall, enter during stall is dropped
    op_ready = 1'b0;
    exp_q.push_back({8'h2A, 8'h05, 4'b1010});
    enter_btn = 1'b1;
    wait_valid(20);
    enter_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); chk("stall_valid", {31'd0, op_valid}, 32'd1); end
    enter_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); chk("stall_valid", {31'd0, op_valid}, 32'd1); end
    enter_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); chk("stall_valid", {31'd0, op_valid}, 32'd1); end
    op_ready = 1'b1;
    tick();
    chk("release_valid", {31'd0, op_valid}, 32'd0);
    chk("release_phase", {30'd0, phase}, 32'd3);
    exp_q.push_back({8'h2A, 8'h05, 4'b1000});
    press(1, 0, 10, 10);

    // Simultaneous enter and sign: one issue, index advanced, sign toggled
    exp_q.push_back({8'h2A, 8'h05, 4'b0001});
    press(1, 1, 10, 10);
    repeat (10) tick();
    chk("dual_sign", {31'd0, sign_mode}, 32'd0);
    chk("dual_phase", {30'd0, phase}, 32'd3);
    chk("queue_drained", exp_q.size(), 32'd0);

    // Reset during an outstanding issue
    op_ready = 1'b0;
    enter_btn = 1'b1;
    wait_valid(20);
    enter_btn = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, op_valid}, 32'd0);
    chk("midrst_phase", {30'd0, phase}, 32'd0);
    chk("midrst_a", {24'd0, operand_a}, 32'd0);
    chk("midrst_func", {28'd0, func}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_phase", {30'd0, phase}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
